// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline sequencing bundle: decoder/cache status in, per-stage stall/flush out.
// The master side drives hazard and cache status; the slave side is the controller.
interface pipeline_stall_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             i_load_instr_e;
   logic [4:0]       i_rd_addr_e;
   logic [4:0]       i_rs1_addr_d;
   logic [4:0]       i_rs2_addr_d;
   logic             i_pc_src_e;
   logic             i_instr_miss;
   logic             i_instr_ready;
   logic             i_data_miss;
   logic             i_data_ready;
   logic             o_stall_f;
   logic             o_stall_d;
   logic             o_stall_e;
   logic             o_stall_m;
   logic             o_flush_d;
   logic             o_flush_e;
   logic             o_flush_w;
   logic [1:0]       o_state;
   logic             o_fault;
   logic [CNT_W-1:0] o_stall_cycles;

   modport master (
      output i_load_instr_e, i_rd_addr_e, i_rs1_addr_d, i_rs2_addr_d, i_pc_src_e,
             i_instr_miss, i_instr_ready, i_data_miss, i_data_ready,
      input  o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e,
             o_flush_w, o_state, o_fault, o_stall_cycles
   );

   modport slave (
      input  i_load_instr_e, i_rd_addr_e, i_rs1_addr_d, i_rs2_addr_d, i_pc_src_e,
             i_instr_miss, i_instr_ready, i_data_miss, i_data_ready,
      output o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e,
             o_flush_w, o_state, o_fault, o_stall_cycles
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Five-stage pipeline stall/flush sequencer: load-use, redirect and cache-miss
// handling with a miss timeout (sticky fault) and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                  i_clk,
   input  logic                  i_arst_n,
   pipeline_stall_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      IMISS = 2'b01,
      DMISS = 2'b10,
      FAULT = 2'b11
   } state_t;

   localparam int unsigned TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t           r_state;
   logic             r_fault;
   logic             r_pend;
   logic             r_kill;
   logic [TW-1:0]    r_tmo;
   logic [CNT_W-1:0] r_stall_cycles;

   logic w_lu;
   logic w_any_rdy;
   logic w_tmo_hit;
   logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
   logic w_flush_d, w_flush_e, w_flush_w;

   assign w_lu = bus.i_load_instr_e && (bus.i_rd_addr_e != 5'd0) &&
                 ((bus.i_rd_addr_e == bus.i_rs1_addr_d) || (bus.i_rd_addr_e == bus.i_rs2_addr_d));
   assign w_any_rdy = bus.i_instr_ready | bus.i_data_ready;
   assign w_tmo_hit = (r_tmo == TMO_LAST) && !w_any_rdy;

   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_stall_m = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_flush_w = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.i_data_miss) begin
               w_stall_f = 1'b1;
               w_stall_d = 1'b1;
               w_stall_e = 1'b1;
               w_stall_m = 1'b1;
               w_flush_w = 1'b1;
            end else begin
               w_stall_f = w_lu | bus.i_instr_miss;
               w_flush_d = bus.i_pc_src_e | bus.i_instr_miss;
               // a clear on D dominates the load-use hold of D
               w_stall_d = w_lu & ~bus.i_pc_src_e & ~bus.i_instr_miss;
               w_flush_e = w_lu | bus.i_pc_src_e;
            end
         end
         IMISS: begin
            // a concurrent D-miss freezes the back end, so a redirect in E is not yet final
            w_stall_f = ~bus.i_instr_ready | bus.i_data_miss;
            w_flush_d = ~bus.i_instr_ready | bus.i_data_miss | r_kill | bus.i_pc_src_e;
            w_flush_e = bus.i_pc_src_e & ~bus.i_data_miss;
            w_stall_d = bus.i_data_miss;
            w_stall_e = bus.i_data_miss;
            w_stall_m = bus.i_data_miss;
            w_flush_w = bus.i_data_miss;
         end
         DMISS: begin
            w_stall_f = ~bus.i_data_ready;
            w_stall_d = ~bus.i_data_ready;
            w_stall_e = ~bus.i_data_ready;
            w_stall_m = ~bus.i_data_ready;
            w_flush_w = ~bus.i_data_ready;
         end
         FAULT: begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state        <= RUN;
         r_fault        <= 1'b0;
         r_pend         <= 1'b0;
         r_kill         <= 1'b0;
         r_tmo          <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_stall_f && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         case (r_state)
            RUN: begin
               if (bus.i_data_miss) begin
                  r_state <= DMISS;
                  r_pend  <= bus.i_instr_miss;
                  r_tmo   <= '0;
               end else if (bus.i_instr_miss) begin
                  r_state <= IMISS;
                  r_tmo   <= '0;
               end
            end
            IMISS: begin
               if (bus.i_instr_ready) begin
                  r_state <= RUN;
                  r_kill  <= 1'b0;
                  r_tmo   <= '0;
               end else if (w_tmo_hit) begin
                  r_state <= FAULT;
                  r_fault <= 1'b1;
               end else if (bus.i_data_miss) begin
                  r_state <= DMISS;
                  r_pend  <= 1'b1;
                  r_tmo   <= '0;
               end else begin
                  r_tmo <= w_any_rdy ? '0 : r_tmo + 1'b1;
                  if (bus.i_pc_src_e)
                     r_kill <= 1'b1;
               end
            end
            DMISS: begin
               if (bus.i_data_ready) begin
                  r_pend <= 1'b0;
                  r_tmo  <= '0;
                  if (r_pend && bus.i_instr_miss) begin
                     r_state <= IMISS;
                  end else begin
                     r_state <= RUN;
                     r_kill  <= 1'b0;
                  end
               end else if (w_tmo_hit) begin
                  r_state <= FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_tmo <= w_any_rdy ? '0 : r_tmo + 1'b1;
                  if (bus.i_instr_ready)
                     r_pend <= 1'b0;
               end
            end
            FAULT: r_fault <= 1'b1;
         endcase
      end
   end

   // stall/flush lines are forced low for the whole time reset is held
   assign bus.o_stall_f      = w_stall_f & i_arst_n;
   assign bus.o_stall_d      = w_stall_d & i_arst_n;
   assign bus.o_stall_e      = w_stall_e & i_arst_n;
   assign bus.o_stall_m      = w_stall_m & i_arst_n;
   assign bus.o_flush_d      = w_flush_d & i_arst_n;
   assign bus.o_flush_e      = w_flush_e & i_arst_n;
   assign bus.o_flush_w      = w_flush_w & i_arst_n;
   assign bus.o_state        = r_state;
   assign bus.o_fault        = r_fault;
   assign bus.o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios with literal checks, plus a
// mode-based reference model compared against every output on each cycle.
module tb_pipeline_stall_ctrl;

   localparam int unsigned TMO  = 8;
   localparam int unsigned CW   = 4;
   localparam int          SMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_stall_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
      .i_clk    (clk),
      .i_arst_n (rst_n),
      .bus      (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic pc, input logic im,
                         input logic ir, input logic dm, input logic dr);
      bus.i_load_instr_e = ld;
      bus.i_rd_addr_e    = rd;
      bus.i_rs1_addr_d   = rs1;
      bus.i_rs2_addr_d   = rs2;
      bus.i_pc_src_e     = pc;
      bus.i_instr_miss   = im;
      bus.i_instr_ready  = ir;
      bus.i_data_miss    = dm;
      bus.i_data_ready   = dr;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // reference model: pipeline mode flags, miss age and stall tally
   logic m_front, m_back, m_fault, m_pend, m_kill;
   int   m_age, m_stalls;

   initial begin
      logic lu, any_rdy, expired, pend_was;
      logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
      logic [1:0] e_state;
      logic [13:0] exp_v, act_v;
      forever begin
         @(negedge clk);
         e_sf = 1'b0; e_sd = 1'b0; e_se = 1'b0; e_sm = 1'b0;
         e_fd = 1'b0; e_fe = 1'b0; e_fw = 1'b0;
         if (!rst_n) begin
            m_front = 1'b0; m_back = 1'b0; m_fault = 1'b0;
            m_pend = 1'b0; m_kill = 1'b0; m_age = 0; m_stalls = 0;
         end else begin
            lu = bus.i_load_instr_e && (bus.i_rd_addr_e != 5'd0) &&
                 (bus.i_rd_addr_e == bus.i_rs1_addr_d || bus.i_rd_addr_e == bus.i_rs2_addr_d);
            if (m_fault) begin
               {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
            end else if (m_back) begin
               {e_sf, e_sd, e_se, e_sm, e_fw} = {5{!bus.i_data_ready}};
            end else if (m_front) begin
               if (bus.i_data_miss) begin
                  {e_sf, e_sd, e_se, e_sm, e_fw, e_fd} = 6'b111111;
               end else begin
                  e_sf = !bus.i_instr_ready;
                  e_fd = !bus.i_instr_ready || m_kill || bus.i_pc_src_e;
                  e_fe = bus.i_pc_src_e;
               end
            end else begin
               if (bus.i_data_miss) begin
                  {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
               end else begin
                  e_sf = lu || bus.i_instr_miss;
                  e_fd = bus.i_pc_src_e || bus.i_instr_miss;
                  e_sd = lu && !e_fd;
                  e_fe = lu || bus.i_pc_src_e;
               end
            end
         end
         e_state = m_fault ? 2'd3 : m_back ? 2'd2 : m_front ? 2'd1 : 2'd0;
         exp_v = {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_state, m_fault, CW'(m_stalls)};
         act_v = {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m, bus.o_flush_d,
                  bus.o_flush_e, bus.o_flush_w, bus.o_state, bus.o_fault, bus.o_stall_cycles};
         check("cycle_model", 32'(act_v), 32'(exp_v));
         if (rst_n) begin
            any_rdy = bus.i_instr_ready || bus.i_data_ready;
            expired = (m_age == int'(TMO) - 1) && !any_rdy;
            if (e_sf && m_stalls < SMAX) m_stalls++;
            if (m_fault) begin
               m_fault = 1'b1;
            end else if (m_back) begin
               if (bus.i_data_ready) begin
                  pend_was = m_pend;
                  m_back = 1'b0; m_pend = 1'b0; m_age = 0;
                  m_front = pend_was && bus.i_instr_miss;
                  if (!m_front) m_kill = 1'b0;
               end else if (expired) begin
                  m_back = 1'b0; m_fault = 1'b1;
               end else begin
                  m_age = any_rdy ? 0 : m_age + 1;
                  if (bus.i_instr_ready) m_pend = 1'b0;
               end
            end else if (m_front) begin
               if (bus.i_instr_ready) begin
                  m_front = 1'b0; m_kill = 1'b0; m_age = 0;
               end else if (expired) begin
                  m_front = 1'b0; m_fault = 1'b1;
               end else if (bus.i_data_miss) begin
                  m_front = 1'b0; m_back = 1'b1; m_pend = 1'b1; m_age = 0;
               end else begin
                  m_age = any_rdy ? 0 : m_age + 1;
                  if (bus.i_pc_src_e) m_kill = 1'b1;
               end
            end else begin
               if (bus.i_data_miss) begin
                  m_back = 1'b1; m_pend = bus.i_instr_miss; m_age = 0;
               end else if (bus.i_instr_miss) begin
                  m_front = 1'b1; m_age = 0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with a load-use pattern present: outputs must stay low
      set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      #3;
      check("rst_stall_f", bus.o_stall_f, 1'b0);
      check("rst_flush_e", bus.o_flush_e, 1'b0);
      check("rst_state", bus.o_state, 2'd0);
      check("rst_fault", bus.o_fault, 1'b0);
      check("rst_cycles", bus.o_stall_cycles, '0);
      do_reset();

      // load-use, then same pattern with rd=x0
      set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      check("lu_stall_f", bus.o_stall_f, 1'b1);
      check("lu_stall_d", bus.o_stall_d, 1'b1);
      check("lu_flush_e", bus.o_flush_e, 1'b1);
      check("lu_flush_d", bus.o_flush_d, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      check("lu_x0_stall_f", bus.o_stall_f, 1'b0);
      check("lu_x0_flush_e", bus.o_flush_e, 1'b0);
      tick();
      check("lu_cycles", bus.o_stall_cycles, 4'd1);

      // branch during load-use; stray ready pulses in RUN
      set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      check("br_flush_d", bus.o_flush_d, 1'b1);
      check("br_flush_e", bus.o_flush_e, 1'b1);
      check("br_stall_f", bus.o_stall_f, 1'b1);
      check("br_stall_d", bus.o_stall_d, 1'b0);
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #2;
      check("br_state", bus.o_state, 2'd0);
      tick();
      idle();
      #2;
      check("rdy_run_state", bus.o_state, 2'd0);

      // I-miss with a redirect while the refill is outstanding
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      check("im0_stall_f", bus.o_stall_f, 1'b1);
      check("im0_flush_d", bus.o_flush_d, 1'b1);
      tick();
      for (int c = 1; c <= 6; c++) begin
         set_in(1'b0, 5'd0, 5'd0, 5'd0, (c == 2), 1'b1, (c == 6), 1'b0, 1'b0);
         #2;
         check("im_state", bus.o_state, 2'd1);
         if (c == 2) check("im_redirect_flush_e", bus.o_flush_e, 1'b1);
         if (c == 6) begin
            check("im_rdy_flush_d", bus.o_flush_d, 1'b1);
            check("im_rdy_stall_f", bus.o_stall_f, 1'b0);
         end
         tick();
      end
      idle();
      #2;
      check("im7_state", bus.o_state, 2'd0);
      check("im7_cycles", bus.o_stall_cycles, 4'd6);

      // simultaneous misses: D first, then the pending I-miss
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      check("sm0_stalls", {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m, bus.o_flush_w}, 5'b11111);
      tick();
      for (int c = 1; c <= 3; c++) begin
         #1;
         check("sm_dmiss_state", bus.o_state, 2'd2);
         tick();
      end
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      check("sm4_stall_f", bus.o_stall_f, 1'b0);
      check("sm4_flush_w", bus.o_flush_w, 1'b0);
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      check("sm5_state", bus.o_state, 2'd1);
      tick();
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      check("sm7_stall_f", bus.o_stall_f, 1'b0);
      tick();
      idle();
      #2;
      check("sm8_state", bus.o_state, 2'd0);
      check("sm8_cycles", bus.o_stall_cycles, 4'd6);

      // I-refill completing during DMISS drops the pending I-miss
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      idle();
      #2;
      check("pend_clr_state", bus.o_state, 2'd0);

      // D-miss timeout into sticky FAULT, then asynchronous reset
      do_reset();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      for (int c = 1; c <= 8; c++) begin
         #1;
         check("to_dmiss_state", bus.o_state, 2'd2);
         tick();
      end
      #1;
      check("to_fault_state", bus.o_state, 2'd3);
      check("to_fault_flag", bus.o_fault, 1'b1);
      check("to_fault_stall", {bus.o_stall_f, bus.o_stall_m, bus.o_flush_w}, 3'b111);
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #2;
      check("to_rdy_state", bus.o_state, 2'd3);
      check("to_rdy_stall_f", bus.o_stall_f, 1'b1);
      tick();
      idle();
      #2;
      check("to_sticky_fault", bus.o_fault, 1'b1);
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      check("to_rst_outs", {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m,
                            bus.o_flush_d, bus.o_flush_e, bus.o_flush_w}, 7'b0);
      check("to_rst_state", bus.o_state, 2'd0);
      check("to_rst_fault", bus.o_fault, 1'b0);
      check("to_rst_cycles", bus.o_stall_cycles, 4'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // stall-cycle counter saturation over a 20-cycle load-use hold
      do_reset();
      set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 14) check("sat_cycles_14", bus.o_stall_cycles, 4'd14);
      end
      check("sat_cycles_20", bus.o_stall_cycles, 4'd15);
      idle();
      tick();
      check("sat_cycles_hold", bus.o_stall_cycles, 4'd15);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
